// File: rtl/OpFormatTypes.sv
`default_nettype none
// ============================================================================
// Module      : OpFormatTypes (package)
// Description : Shared FPU operation codes, rounding modes, flag layout and
//               small rounding/normalisation helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package OpFormatTypes;

    typedef enum logic [4:0] {
        FC_ADD, FC_SUB, FC_MUL, FC_DIV, FC_SQRT,
        FC_FMADD, FC_FMSUB, FC_FNMSUB, FC_FNMADD,
        FC_SGNJ, FC_SGNJN, FC_SGNJX,
        FC_FMIN, FC_FMAX,
        FC_FEQ, FC_FLT, FC_FLE,
        FC_FCLASS,
        FC_FCVT_WS, FC_FCVT_WUS, FC_FCVT_SW, FC_FCVT_SWU,
        FC_FMV_XW, FC_FMV_WX
    } FPU_Code;

    typedef enum logic [2:0] {
        RNE = 3'd0,
        RTZ = 3'd1,
        RDN = 3'd2,
        RUP = 3'd3,
        RMM = 3'd4
    } Rounding_Mode;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } FFlags_Path;

    localparam logic [31:0] c_CANON_NAN = 32'h7FC0_0000;

    // Increment decision for a truncated magnitude; encodings 5-7 fall into RNE.
    function automatic logic round_up(input Rounding_Mode rm, input logic sign,
                                      input logic lsb, input logic guard,
                                      input logic sticky);
        logic inc;
        case (rm)
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & (guard | sticky);
            RUP:     inc = ~sign & (guard | sticky);
            RMM:     inc = guard;
            default: inc = guard & (sticky | lsb);
        endcase
        return inc;
    endfunction

    function automatic logic [5:0] clz32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

endpackage : OpFormatTypes
`default_nettype wire

// File: rtl/fp32_other_core.sv
`default_nettype none
// ============================================================================
// Module      : fp32_other_core
// Description : Combinational FP32 sign-inject, min/max, compare, classify,
//               integer conversion and move operations.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_other_core
    import OpFormatTypes::*;
(
    input  logic [31:0]  lhs,
    input  logic [31:0]  rhs,
    input  FPU_Code      fpuCode,
    input  Rounding_Mode rm,
    output logic [31:0]  result,
    output FFlags_Path   fflags
);

    logic w_a_sign, w_a_exp_max, w_a_exp_zero, w_a_man_nz;
    logic w_a_nan, w_a_snan, w_a_qnan, w_a_zero, w_a_inf, w_a_sub, w_a_norm;
    logic w_b_nan, w_b_snan;
    logic w_any_nan, w_any_snan, w_both_zero;
    logic w_ord_lt, w_flt, w_feq, w_fle;
    logic [9:0] w_class;

    assign w_a_sign     = lhs[31];
    assign w_a_exp_max  = &lhs[30:23];
    assign w_a_exp_zero = ~|lhs[30:23];
    assign w_a_man_nz   = |lhs[22:0];
    assign w_a_nan      = w_a_exp_max & w_a_man_nz;
    assign w_a_snan     = w_a_nan & ~lhs[22];
    assign w_a_qnan     = w_a_nan & lhs[22];
    assign w_a_zero     = ~|lhs[30:0];
    assign w_a_inf      = w_a_exp_max & ~w_a_man_nz;
    assign w_a_sub      = w_a_exp_zero & w_a_man_nz;
    assign w_a_norm     = ~w_a_exp_zero & ~w_a_exp_max;

    assign w_b_nan      = (&rhs[30:23]) & (|rhs[22:0]);
    assign w_b_snan     = w_b_nan & ~rhs[22];

    assign w_any_nan    = w_a_nan | w_b_nan;
    assign w_any_snan   = w_a_snan | w_b_snan;
    assign w_both_zero  = w_a_zero & (~|rhs[30:0]);

    // Sign-magnitude ordering in which -0 sorts below +0; used directly by min/max.
    assign w_ord_lt = (lhs[31] != rhs[31]) ? lhs[31] :
                      (lhs[31] ? (rhs[30:0] < lhs[30:0]) : (lhs[30:0] < rhs[30:0]));
    assign w_flt    = w_ord_lt & ~w_both_zero;
    assign w_feq    = (lhs == rhs) | w_both_zero;
    assign w_fle    = w_flt | w_feq;

    assign w_class = {w_a_qnan, w_a_snan,
                      ~w_a_sign & w_a_inf,  ~w_a_sign & w_a_norm,
                      ~w_a_sign & w_a_sub,  ~w_a_sign & w_a_zero,
                      w_a_sign & w_a_zero,  w_a_sign & w_a_sub,
                      w_a_sign & w_a_norm,  w_a_sign & w_a_inf};

    // Float to integer: truncated magnitude plus guard/sticky, then rounding.
    logic [7:0]  w_exp;
    logic [23:0] w_sig;
    logic [49:0] w_sh;
    logic [31:0] w_int;
    logic        w_g, w_st, w_cvt_inc, w_inexact, w_huge;
    logic [32:0] w_mag;

    assign w_exp = lhs[30:23];
    assign w_sig = {~w_a_exp_zero, lhs[22:0]};

    always_comb begin
        w_sh  = '0;
        w_int = '0;
        w_g   = 1'b0;
        w_st  = 1'b0;
        if (w_exp >= 8'd150) begin
            w_int = {8'b0, w_sig} << (w_exp - 8'd150);
        end else if (w_exp >= 8'd125) begin
            w_sh  = {w_sig, 26'b0} >> (8'd150 - w_exp);
            w_int = {8'b0, w_sh[49:26]};
            w_g   = w_sh[25];
            w_st  = |w_sh[24:0];
        end else begin
            w_st  = |lhs[30:0];
        end
    end

    assign w_cvt_inc = round_up(rm, w_a_sign, w_int[0], w_g, w_st);
    assign w_mag     = {1'b0, w_int} + {32'b0, w_cvt_inc};
    assign w_inexact = w_g | w_st;
    assign w_huge    = w_exp >= 8'd159;

    // Integer to float: normalise so bit 31 is the hidden one.
    logic        w_i_neg, w_i_inc;
    logic [31:0] w_i_mag, w_norm;
    logic [5:0]  w_lz;
    logic [7:0]  w_i_exp;
    logic [30:0] w_i_body;

    assign w_i_neg  = (fpuCode == FC_FCVT_SW) & lhs[31];
    assign w_i_mag  = w_i_neg ? (~lhs + 32'd1) : lhs;
    assign w_lz     = clz32(w_i_mag);
    assign w_norm   = w_i_mag << w_lz;
    assign w_i_exp  = 8'd158 - {2'b0, w_lz};
    assign w_i_inc  = round_up(rm, w_i_neg, w_norm[8], w_norm[7], |w_norm[6:0]);
    assign w_i_body = {w_i_exp, w_norm[30:8]} + {30'b0, w_i_inc};

    always_comb begin
        result = '0;
        fflags = '0;
        case (fpuCode)
            FC_SGNJ:  result = {rhs[31], lhs[30:0]};
            FC_SGNJN: result = {~rhs[31], lhs[30:0]};
            FC_SGNJX: result = {lhs[31] ^ rhs[31], lhs[30:0]};
            FC_FMIN, FC_FMAX: begin
                fflags.nv = w_any_snan;
                if (w_a_nan & w_b_nan)  result = c_CANON_NAN;
                else if (w_a_nan)       result = rhs;
                else if (w_b_nan)       result = lhs;
                else                    result = ((fpuCode == FC_FMIN) == w_ord_lt) ? lhs : rhs;
            end
            FC_FEQ: begin
                fflags.nv = w_any_snan;
                result    = {31'b0, w_feq & ~w_any_nan};
            end
            FC_FLT: begin
                fflags.nv = w_any_nan;
                result    = {31'b0, w_flt & ~w_any_nan};
            end
            FC_FLE: begin
                fflags.nv = w_any_nan;
                result    = {31'b0, w_fle & ~w_any_nan};
            end
            FC_FCLASS: result = {22'b0, w_class};
            FC_FMV_XW, FC_FMV_WX: result = lhs;
            FC_FCVT_WS: begin
                if (w_a_nan) begin
                    result = 32'h7FFF_FFFF; fflags.nv = 1'b1;
                end else if (w_huge) begin
                    result = w_a_sign ? 32'h8000_0000 : 32'h7FFF_FFFF; fflags.nv = 1'b1;
                end else if (!w_a_sign && w_mag > 33'h0_7FFF_FFFF) begin
                    result = 32'h7FFF_FFFF; fflags.nv = 1'b1;
                end else if (w_a_sign && w_mag > 33'h0_8000_0000) begin
                    result = 32'h8000_0000; fflags.nv = 1'b1;
                end else begin
                    result    = w_a_sign ? (~w_mag[31:0] + 32'd1) : w_mag[31:0];
                    fflags.nx = w_inexact;
                end
            end
            FC_FCVT_WUS: begin
                if (w_a_nan) begin
                    result = 32'hFFFF_FFFF; fflags.nv = 1'b1;
                end else if (w_a_sign) begin
                    // A negative input is legal only if it rounds to zero.
                    if (w_huge || w_mag != 33'd0) fflags.nv = 1'b1;
                    else                          fflags.nx = w_inexact;
                end else if (w_huge || w_mag[32]) begin
                    result = 32'hFFFF_FFFF; fflags.nv = 1'b1;
                end else begin
                    result    = w_mag[31:0];
                    fflags.nx = w_inexact;
                end
            end
            FC_FCVT_SW, FC_FCVT_SWU: begin
                if (w_i_mag != 32'd0) result = {w_i_neg, w_i_body};
                fflags.nx = |w_norm[7:0];
            end
            default: begin
                result = '0;
                fflags = '0;
            end
        endcase
    end

endmodule : fp32_other_core
`default_nettype wire

// File: rtl/fp32_pipelined_other.sv
`default_nettype none
// ============================================================================
// Module      : fp32_pipelined_other
// Description : Registered wrapper around fp32_other_core: one input stage
//               followed by PIPELINE_DEPTH-2 result stages.
// Revision    : 1.0 - initial release
// ============================================================================
module fp32_pipelined_other
    import OpFormatTypes::*;
#(
    parameter int PIPELINE_DEPTH = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  lhs,
    input  logic [31:0]  rhs,
    input  FPU_Code      fpuCode,
    input  Rounding_Mode rm,
    output logic [31:0]  result,
    output logic [4:0]   fflags
);

    localparam int c_OUT_STAGES = PIPELINE_DEPTH - 2;

    typedef struct packed {
        logic [31:0]  lhs;
        logic [31:0]  rhs;
        FPU_Code      code;
        Rounding_Mode rm;
    } in_stage_t;

    in_stage_t   in_d, in_q;
    logic [31:0] w_core_result;
    FFlags_Path  w_core_flags;

    always_comb begin
        in_d.lhs  = lhs;
        in_d.rhs  = rhs;
        in_d.code = fpuCode;
        in_d.rm   = rm;
    end

    always_ff @(posedge clk) begin
        if (rst) in_q <= '0;
        else     in_q <= in_d;
    end

    fp32_other_core u_core (
        .lhs     (in_q.lhs),
        .rhs     (in_q.rhs),
        .fpuCode (in_q.code),
        .rm      (in_q.rm),
        .result  (w_core_result),
        .fflags  (w_core_flags)
    );

    generate
        if (c_OUT_STAGES == 0) begin : g_no_out_stage
            // The reset input stage decodes as FC_ADD, so outputs read zero.
            assign result = w_core_result;
            assign fflags = w_core_flags;
        end else begin : g_out_stages
            logic [36:0] out_d [c_OUT_STAGES];
            logic [36:0] out_q [c_OUT_STAGES];

            always_comb begin
                out_d[0] = {w_core_result, w_core_flags};
                for (int i = 1; i < c_OUT_STAGES; i++) begin
                    out_d[i] = out_q[i-1];
                end
            end

            always_ff @(posedge clk) begin
                for (int i = 0; i < c_OUT_STAGES; i++) begin
                    if (rst) out_q[i] <= '0;
                    else     out_q[i] <= out_d[i];
                end
            end

            assign result = out_q[c_OUT_STAGES-1][36:5];
            assign fflags = out_q[c_OUT_STAGES-1][4:0];
        end
    endgenerate

endmodule : fp32_pipelined_other
`default_nettype wire

// File: tb/tb_fp32_pipelined_other.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp32_pipelined_other
// Description : Scoreboard bench for fp32_pipelined_other with hand-computed
//               expected results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp32_pipelined_other;
    import OpFormatTypes::*;

    localparam int DEPTH = 5;
    localparam logic [4:0] c_NV = 5'h10;
    localparam logic [4:0] c_NX = 5'h01;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  lhs, rhs;
    FPU_Code      fpuCode;
    Rounding_Mode rm;
    logic [31:0]  result;
    logic [4:0]   fflags;

    fp32_pipelined_other #(.PIPELINE_DEPTH(DEPTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .lhs     (lhs),
        .rhs     (rhs),
        .fpuCode (fpuCode),
        .rm      (rm),
        .result  (result),
        .fflags  (fflags)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        FPU_Code      code;
        logic [31:0]  a;
        logic [31:0]  b;
        Rounding_Mode rm;
        logic [31:0]  er;
        logic [4:0]   ef;
    } vec_t;

    typedef struct {
        int          due;
        string       tag;
        logic [31:0] er;
        logic [4:0]  ef;
    } sb_t;

    vec_t vecs[$];
    sb_t  sb[$];
    int   cyc     = 0;
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Advance one edge and retire any scoreboard entry due on it.
    task automatic step();
        sb_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_eq({e.tag, "_res"}, result, e.er);
            check_eq({e.tag, "_flg"}, {27'b0, fflags}, {27'b0, e.ef});
        end
    endtask

    task automatic drive(input vec_t v);
        sb_t e;
        lhs     = v.a;
        rhs     = v.b;
        fpuCode = v.code;
        rm      = v.rm;
        e.due   = cyc + DEPTH - 1;
        e.tag   = v.tag;
        e.er    = v.er;
        e.ef    = v.ef;
        sb.push_back(e);
    endtask

    task automatic drive_idle();
        lhs = '0; rhs = '0; fpuCode = FC_ADD; rm = RNE;
    endtask

    initial begin
        vecs.push_back('{"sgnjx",     FC_SGNJX,   32'h3F800000, 32'hBF800000, RNE, 32'hBF800000, 5'h00});
        vecs.push_back('{"sgnj",      FC_SGNJ,    32'h3F800000, 32'hBF800000, RNE, 32'hBF800000, 5'h00});
        vecs.push_back('{"sgnjn",     FC_SGNJN,   32'h3F800000, 32'hBF800000, RNE, 32'h3F800000, 5'h00});
        vecs.push_back('{"cvtws_rne", FC_FCVT_WS, 32'h40200000, 32'h0,        RNE, 32'd2,        c_NX});
        vecs.push_back('{"cvtws_rup", FC_FCVT_WS, 32'h40200000, 32'h0,        RUP, 32'd3,        c_NX});
        vecs.push_back('{"cvtws_rmm", FC_FCVT_WS, 32'h40200000, 32'h0,        RMM, 32'd3,        c_NX});
        vecs.push_back('{"cvtws_rtz", FC_FCVT_WS, 32'hBFC00000, 32'h0,        RTZ, 32'hFFFFFFFF, c_NX});
        vecs.push_back('{"cvtws_rdn", FC_FCVT_WS, 32'hBFC00000, 32'h0,        RDN, 32'hFFFFFFFE, c_NX});
        vecs.push_back('{"cvtws_pov", FC_FCVT_WS, 32'h4F000000, 32'h0,        RNE, 32'h7FFFFFFF, c_NV});
        vecs.push_back('{"cvtws_min", FC_FCVT_WS, 32'hCF000000, 32'h0,        RNE, 32'h80000000, 5'h00});
        vecs.push_back('{"cvtws_nan", FC_FCVT_WS, 32'h7FC00000, 32'h0,        RNE, 32'h7FFFFFFF, c_NV});
        vecs.push_back('{"cvtwu_nx",  FC_FCVT_WUS,32'hBF000000, 32'h0,        RNE, 32'h0,        c_NX});
        vecs.push_back('{"cvtwu_neg", FC_FCVT_WUS,32'hBF800000, 32'h0,        RNE, 32'h0,        c_NV});
        vecs.push_back('{"cvtwu_nan", FC_FCVT_WUS,32'h7FC00000, 32'h0,        RNE, 32'hFFFFFFFF, c_NV});
        vecs.push_back('{"fmin_qnan", FC_FMIN,    32'h7FC00000, 32'h3F800000, RNE, 32'h3F800000, 5'h00});
        vecs.push_back('{"fmin_zero", FC_FMIN,    32'h80000000, 32'h00000000, RNE, 32'h80000000, 5'h00});
        vecs.push_back('{"fmin_snan", FC_FMIN,    32'h7F800001, 32'h3F800000, RNE, 32'h3F800000, c_NV});
        vecs.push_back('{"fmax_2nan", FC_FMAX,    32'h7F800001, 32'h7FC00000, RNE, 32'h7FC00000, c_NV});
        vecs.push_back('{"fmax_zero", FC_FMAX,    32'h80000000, 32'h00000000, RNE, 32'h00000000, 5'h00});
        vecs.push_back('{"flt_nan",   FC_FLT,     32'h7FC00000, 32'h3F800000, RNE, 32'h0,        c_NV});
        vecs.push_back('{"feq_nan",   FC_FEQ,     32'h7FC00000, 32'h3F800000, RNE, 32'h0,        5'h00});
        vecs.push_back('{"feq_zero",  FC_FEQ,     32'h00000000, 32'h80000000, RNE, 32'h1,        5'h00});
        vecs.push_back('{"fle_zero",  FC_FLE,     32'h80000000, 32'h00000000, RNE, 32'h1,        5'h00});
        vecs.push_back('{"flt_neg",   FC_FLT,     32'hC0000000, 32'hBF800000, RNE, 32'h1,        5'h00});
        vecs.push_back('{"class_ninf",FC_FCLASS,  32'hFF800000, 32'h0,        RNE, 32'h001,      5'h00});
        vecs.push_back('{"class_snan",FC_FCLASS,  32'h7F800001, 32'h0,        RNE, 32'h100,      5'h00});
        vecs.push_back('{"class_psub",FC_FCLASS,  32'h00000001, 32'h0,        RNE, 32'h020,      5'h00});
        vecs.push_back('{"cvtsw_rne", FC_FCVT_SW, 32'h01000001, 32'h0,        RNE, 32'h4B800000, c_NX});
        vecs.push_back('{"cvtsw_m1",  FC_FCVT_SW, 32'hFFFFFFFF, 32'h0,        RNE, 32'hBF800000, 5'h00});
        vecs.push_back('{"cvtsw_0",   FC_FCVT_SW, 32'h00000000, 32'h0,        RNE, 32'h00000000, 5'h00});
        vecs.push_back('{"cvtswu_max",FC_FCVT_SWU,32'hFFFFFFFF, 32'h0,        RNE, 32'h4F800000, c_NX});
        vecs.push_back('{"fmv_xw",    FC_FMV_XW,  32'h12345678, 32'h0,        RNE, 32'h12345678, 5'h00});
        vecs.push_back('{"fmv_wx",    FC_FMV_WX,  32'hDEADBEEF, 32'h0,        RNE, 32'hDEADBEEF, 5'h00});
        vecs.push_back('{"fadd_none", FC_ADD,     32'h3F800000, 32'h3F800000, RNE, 32'h0,        5'h00});

        rst = 1'b1;
        drive_idle();
        step();
        step();
        check_eq("reset_res", result, 32'h0);
        check_eq("reset_flg", {27'b0, fflags}, 32'h0);
        rst = 1'b0;

        // Back-to-back stream; each vector issues on consecutive cycles.
        foreach (vecs[i]) begin
            drive(vecs[i]);
            step();
        end
        drive_idle();
        for (int i = 0; i < DEPTH; i++) step();
        check_eq("sb_drain", sb.size(), 0);

        // Reset with three operations in flight: they must never surface.
        drive(vecs[0]); step();
        drive(vecs[3]); step();
        drive(vecs[17]); step();
        drive_idle();
        rst = 1'b1;
        sb.delete();
        step();
        check_eq("inflight_rst_res", result, 32'h0);
        check_eq("inflight_rst_flg", {27'b0, fflags}, 32'h0);
        rst = 1'b0;
        drive(vecs[12]);
        step();
        drive_idle();
        for (int i = 0; i < DEPTH - 2; i++) begin
            check_eq("flushed_res", result, 32'h0);
            check_eq("flushed_flg", {27'b0, fflags}, 32'h0);
            step();
        end
        for (int i = 0; i < DEPTH; i++) step();
        check_eq("sb_drain_post_rst", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_fp32_pipelined_other
`default_nettype wire

// File: doc/fp32_pipelined_other.md
FP32_PIPELINED_OTHER -- requirements
Module: fp32_pipelined_other

Interface
REQ-001 SHALL have parameter PIPELINE_DEPTH, default 5, execution-stage depth; legal values 2 and above; result latency is PIPELINE_DEPTH-1 cycles.
REQ-002 SHALL have port clk  in  1  rising-edge clock.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have port lhs  in  32  operand A: FP32 bits, or integer for FCVT.S.W/WU and FMV.W.X.
REQ-005 SHALL have port rhs  in  32  operand B, FP32 bits.
REQ-006 SHALL have port fpuCode  in  FPU_Code (5b)  operation select.
REQ-007 SHALL have port rm  in  Rounding_Mode (3b)  resolved rounding mode (RNE=0, RTZ=1, RDN=2, RUP=3, RMM=4).
REQ-008 SHALL have port result  out  32  operation result.
REQ-009 SHALL have port fflags  out  5  exception flags {NV,DZ,OF,UF,NX}, bit4 down to bit0.

Function
REQ-010 SHALL register inputs every cycle with no enable or valid; the result for inputs sampled at edge N SHALL appear on result/fflags after edge N+PIPELINE_DEPTH-2, so total latency is PIPELINE_DEPTH-1 cycles; back-to-back issue every cycle SHALL be supported.
REQ-011 FC_SGNJ/SGNJN/SGNJX SHALL return {lhs[31] replaced by rhs[31], ~rhs[31], or lhs[31]^rhs[31], lhs[30:0]}, with flags 0.
REQ-012 FC_FMIN/FMAX SHALL treat -0 as less than +0; if exactly one operand is NaN, SHALL return the other operand; if both are NaN, SHALL return 0x7FC00000; NV SHALL be set if either operand is an sNaN.
REQ-013 FC_FEQ SHALL return 1 or 0, returning 0 if any operand is NaN, with NV only for sNaN; FC_FLT/FLE SHALL return 0 and set NV if any operand is NaN; +0 and -0 SHALL compare equal.
REQ-014 FC_FCLASS SHALL return a 10-bit one-hot value zero-extended: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN; flags 0.
REQ-015 FC_FMV_XW and FC_FMV_WX SHALL copy lhs unchanged, with flags 0.
REQ-016 FC_FCVT_WS SHALL round lhs to a signed int32 per rm; in-range inexact results SHALL set NX; NaN or positive overflow SHALL return 0x7FFFFFFF with NV; negative overflow SHALL return 0x80000000 with NV.
REQ-017 FC_FCVT_WUS SHALL round to uint32; NaN or overflow SHALL return 0xFFFFFFFF with NV; a value that rounds below 0 SHALL return 0 with NV; a negative value that rounds to 0 SHALL return 0 with NX only.
REQ-018 FC_FCVT_SW/SWU SHALL convert a signed or unsigned int32 to FP32, rounding per rm, and SHALL set NX if inexact; input 0 SHALL return +0.
REQ-019 RMM SHALL round ties away from zero; an unsupported rm value (5-7) SHALL behave as RNE.
REQ-020 Codes not handled here (ADD, SUB, MUL, DIV, SQRT, FMA family) SHALL produce result 0 and flags 0; DZ, OF and UF SHALL always be 0.

Reset
REQ-021 While rst is high at a clock edge, all pipeline registers SHALL clear; after the edge, result=0 and fflags=0.
REQ-022 Operations in flight at reset SHALL be discarded; inputs sampled on the first edge after rst falls SHALL be valid.

Structure
REQ-023 The FPU_Code enum (FC_ADD, FC_SUB, FC_MUL, FC_DIV, FC_SQRT, FC_FMADD, FC_FMSUB, FC_FNMSUB, FC_FNMADD, FC_SGNJ, FC_SGNJN, FC_SGNJX, FC_FMIN, FC_FMAX, FC_FEQ, FC_FLT, FC_FLE, FC_FCLASS, FC_FCVT_WS, FC_FCVT_WUS, FC_FCVT_SW, FC_FCVT_SWU, FC_FMV_XW, FC_FMV_WX), the Rounding_Mode enum and the FFlags_Path type SHALL live in the shared OpFormatTypes package.
REQ-024 A combinational sub-module fp32_other_core (lhs, rhs, fpuCode, rm -> result, fflags) SHALL compute the results; the top level SHALL add only the PIPELINE_DEPTH-1 stage register chain.

Verification
REQ-025 FCVT_WS, lhs=0x40200000 (2.5): rm=RNE -> result 2, NX; rm=RUP -> 3, NX; rm=RMM -> 3, NX.
REQ-026 FMIN(0x7FC00000, 0x3F800000) -> 0x3F800000, flags 0; FMIN(0x80000000, 0x00000000) -> 0x80000000; FMAX(0x7F800001, 0x7FC00000) -> 0x7FC00000, NV.
REQ-027 FLT(0x7FC00000, 0x3F800000) -> 0, NV; FEQ on the same operands -> 0, flags 0; FLE(0x80000000, 0x00000000) -> 1.
REQ-028 FCLASS 0xFF800000 -> 0x001, 0x7F800001 -> 0x100, 0x00000001 -> 0x020; FCVT_SW 16777217 with RNE -> 0x4B800000, NX.
REQ-029 With PIPELINE_DEPTH=5, issue SGNJX(0x3F800000, 0xBF800000) and three other ops on consecutive cycles; each result SHALL appear exactly 4 cycles after issue, the first being 0xBF800000; asserting rst while they are in flight SHALL give result=0 and fflags=0 after the edge.
